// File: rtl/ternary_popcount_pkg.sv
// Shared definitions for the ternary popcount accumulator: activation
// encodings, FSM state type and the popcount width helper.
// Optional build macro: TERNARY_POPCOUNT_APPROX_EN (used in popcount_tree).
package ternary_popcount_pkg;

    typedef logic [1:0] act_t;

    localparam act_t ACT_POS  = 2'b01;
    localparam act_t ACT_NEG  = 2'b11;
    localparam act_t ACT_ZERO = 2'b00;

    typedef enum logic {
        ST_ACC,
        ST_DONE
    } state_t;

    // Number of bits needed to hold a count of 0..w set bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ternary_popcount_accum_popcount_tree.sv
// Combinational popcount of one IN_W-bit beat.
// Build macro TERNARY_POPCOUNT_APPROX_EN: when defined, the count LSB is
// forced to 0 (count truncated to even); otherwise the count is exact.
module popcount_tree
    import ternary_popcount_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic [IN_W-1:0]               bits_i,
    output logic [cnt_width(IN_W)-1:0]    count_o
);

    localparam int CW = cnt_width(IN_W);

    logic [CW-1:0] exactCnt;

    // Sum every input bit; synthesis balances the chain into an adder tree.
    always_comb begin
        exactCnt = '0;
        for (int i = 0; i < IN_W; i++) begin
            exactCnt = exactCnt + CW'(bits_i[i]);
        end
    end

`ifdef TERNARY_POPCOUNT_APPROX_EN
    // Approximate count: dropping the LSB removes one adder bit slice.
    assign count_o = {exactCnt[CW-1:1], 1'b0};
`else
    assign count_o = exactCnt;
`endif

endmodule

// File: rtl/ternary_popcount_accum.sv
// Multi-beat ternary neuron accumulator: sums popcount(pos) - popcount(neg)
// over up to MAX_BEATS beats and emits a ternary activation against
// programmable thresholds. Optional macro TERNARY_POPCOUNT_APPROX_EN selects
// the approximate (even-truncated) per-beat counts inside popcount_tree.
module ternary_popcount_accum
    import ternary_popcount_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int MAX_BEATS = 4,
    parameter int ACC_W     = $clog2(IN_W * MAX_BEATS + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_pos,
    input  logic [IN_W-1:0]         in_neg,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [1:0]              out_act,
    output logic                    out_trunc
);

    localparam int CW  = cnt_width(IN_W);
    localparam int BCW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [BCW-1:0] LAST_CNT = BCW'(MAX_BEATS - 1);

    logic [CW-1:0] posCnt;
    logic [CW-1:0] negCnt;

    popcount_tree #(.IN_W(IN_W)) u_pos_cnt (.bits_i(in_pos), .count_o(posCnt));
    popcount_tree #(.IN_W(IN_W)) u_neg_cnt (.bits_i(in_neg), .count_o(negCnt));

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [BCW-1:0]          beat_cnt_q, beat_cnt_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    act_t                    act_q, act_d;
    logic                    trunc_q, trunc_d;

    logic signed [ACC_W-1:0] accNext;
    logic                    closeBeat;
    act_t                    actNext;

    // Running sum including the current beat, close decision and activation.
    always_comb begin
        accNext   = acc_q + $signed(ACC_W'(posCnt)) - $signed(ACC_W'(negCnt));
        closeBeat = in_last || (beat_cnt_q == LAST_CNT);
        if (accNext > thr_hi) begin
            actNext = ACT_POS;
        end else if (accNext < thr_lo) begin
            actNext = ACT_NEG;
        end else begin
            actNext = ACT_ZERO;
        end
    end

    // Next-state logic and handshake outputs; DONE stalls new beats.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        sum_d      = sum_q;
        act_d      = act_q;
        trunc_d    = trunc_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d      = accNext;
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    if (closeBeat) begin
                        state_d = ST_DONE;
                        sum_d   = accNext;
                        act_d   = actNext;
                        trunc_d = !in_last;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d      = '0;
                    beat_cnt_d = '0;
                    trunc_d    = 1'b0;
                    state_d    = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // State and result registers; reset discards any partial evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            sum_q      <= '0;
            act_q      <= ACT_ZERO;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            sum_q      <= sum_d;
            act_q      <= act_d;
            trunc_q    <= trunc_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_act   = act_q;
    assign out_trunc = trunc_q;

endmodule

// File: tb/tb_ternary_popcount_accum.sv
// Self-checking bench for ternary_popcount_accum (IN_W=16, MAX_BEATS=4).
// Honours TERNARY_POPCOUNT_APPROX_EN in its reference model.
module tb_ternary_popcount_accum;

    localparam int IN_W      = 16;
    localparam int MAX_BEATS = 4;
    localparam int ACC_W     = $clog2(IN_W * MAX_BEATS + 1) + 1;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [IN_W-1:0]         in_pos;
    logic [IN_W-1:0]         in_neg;
    logic                    in_last;
    logic signed [ACC_W-1:0] thr_hi;
    logic signed [ACC_W-1:0] thr_lo;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [1:0]              out_act;
    logic                    out_trunc;

    int checks = 0;
    int errors = 0;

    ternary_popcount_accum #(
        .IN_W(IN_W),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pos(in_pos),
        .in_neg(in_neg),
        .in_last(in_last),
        .thr_hi(thr_hi),
        .thr_lo(thr_lo),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_act(out_act),
        .out_trunc(out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: number of set bits, optionally truncated to even.
    function automatic int pc(input logic [IN_W-1:0] v);
        int c;
        c = $countones(v);
`ifdef TERNARY_POPCOUNT_APPROX_EN
        c = (c / 2) * 2;
`endif
        return c;
    endfunction

    // Reference: ternary activation with +1 taking priority.
    function automatic logic [1:0] refAct(input int s, input int hi, input int lo);
        if (s > hi) return 2'b01;
        if (s < lo) return 2'b11;
        return 2'b00;
    endfunction

    // Present one beat and hold it until the DUT accepts it (bounded).
    task automatic doBeat(input logic [IN_W-1:0] p, input logic [IN_W-1:0] n,
                          input logic l, input int hi, input int lo);
        int waitCnt;
        in_valid = 1'b1;
        in_pos   = p;
        in_neg   = n;
        in_last  = l;
        thr_hi   = ACC_W'(hi);
        thr_lo   = ACC_W'(lo);
        waitCnt  = 0;
        while (!in_ready && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("[TB] FAIL beat_accept_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Complete the result handshake in one cycle.
    task automatic drainResult();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 ||
            out_act !== 2'b00 || out_trunc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state rdy=%0b vld=%0b sum=%0d act=%b trunc=%0b required 1 0 0 00 0",
                     in_ready, out_valid, out_sum, out_act, out_trunc);
        end
        checks++;
        doBeat(16'hFFFF, 16'h0000, 1'b0, 0, 0);
        doBeat(16'hFFFF, 16'h0000, 1'b0, 0, 0);
        #2 rst = 1'b1;
        #1;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_act !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mid_reset rdy=%0b vld=%0b sum=%0d act=%b required 1 0 0 00",
                     in_ready, out_valid, out_sum, out_act);
        end
        checks++;
        @(posedge clk); #1;
        rst = 1'b0;
        doBeat(16'h000F, 16'h0000, 1'b1, 0, 0);
        if (out_valid !== 1'b1 || out_sum !== ACC_W'(pc(16'h000F))) begin
            errors++;
            $display("[TB] FAIL post_reset_beat vld=%0b sum=%0d required 1 %0d",
                     out_valid, out_sum, pc(16'h000F));
        end
        checks++;
        drainResult();
    endtask

    task automatic test_single();
        int s;
        s = pc(16'h00FF) - pc(16'h0003);
        doBeat(16'h00FF, 16'h0003, 1'b1, 4, -4);
        if (out_valid !== 1'b1 || out_sum !== ACC_W'(s) || out_act !== refAct(s, 4, -4) ||
            out_trunc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_beat vld=%0b sum=%0d act=%b trunc=%0b required 1 %0d %b 0",
                     out_valid, out_sum, out_act, out_trunc, s, refAct(s, 4, -4));
        end
        checks++;
        drainResult();
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== ACC_W'(s)) begin
            errors++;
            $display("[TB] FAIL single_after_hs rdy=%0b vld=%0b sum=%0d required 1 0 %0d",
                     in_ready, out_valid, out_sum, s);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        int s;
        logic [1:0] a;
        s = pc(16'h000F) - pc(16'hFF00) + pc(16'h0001) - pc(16'h0003);
        a = refAct(s, 0, -2);
        doBeat(16'h000F, 16'hFF00, 1'b0, 0, -2);
        doBeat(16'h0001, 16'h0000, 1'b0, 0, -2);
        doBeat(16'h0000, 16'h0003, 1'b1, 0, -2);
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== ACC_W'(s) ||
                out_act !== a || out_trunc !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold cyc=%0d vld=%0b rdy=%0b sum=%0d act=%b required 1 0 %0d %b",
                         i, out_valid, in_ready, out_sum, out_act, s, a);
            end
            checks++;
            @(posedge clk); #1;
        end
        drainResult();
    endtask

    task automatic test_truncation();
        int s;
        int waitCnt;
        s = 4 * pc(16'hFFFF);
        for (int i = 0; i < MAX_BEATS; i++) doBeat(16'hFFFF, 16'h0000, 1'b0, 10, -10);
        if (out_valid !== 1'b1 || out_sum !== ACC_W'(s) || out_trunc !== 1'b1 || out_act !== 2'b01) begin
            errors++;
            $display("[TB] FAIL truncation vld=%0b sum=%0d trunc=%0b act=%b required 1 %0d 1 01",
                     out_valid, out_sum, out_trunc, out_act, s);
        end
        checks++;
        in_valid = 1'b1;
        in_pos   = 16'h0003;
        in_neg   = 16'h0000;
        in_last  = 1'b1;
        thr_hi   = '0;
        thr_lo   = '0;
        repeat (3) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || out_sum !== ACC_W'(s)) begin
                errors++;
                $display("[TB] FAIL fifth_stalled rdy=%0b sum=%0d required 0 %0d", in_ready, out_sum, s);
            end
            checks++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        waitCnt = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (out_valid !== 1'b1 || out_sum !== ACC_W'(pc(16'h0003)) || out_trunc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fifth_after_hs vld=%0b sum=%0d trunc=%0b required 1 %0d 0",
                     out_valid, out_sum, out_trunc, pc(16'h0003));
        end
        checks++;
        drainResult();
    endtask

    task automatic test_thresholds();
        doBeat(16'hAAAA, 16'hAAAA, 1'b1, 0, 0);
        if (out_sum !== '0 || out_act !== 2'b00) begin
            errors++;
            $display("[TB] FAIL zero_band sum=%0d act=%b required 0 00", out_sum, out_act);
        end
        checks++;
        drainResult();
        doBeat(16'hAAAA, 16'hAAAA, 1'b1, -1, 3);
        if (out_sum !== '0 || out_act !== 2'b01) begin
            errors++;
            $display("[TB] FAIL thr_priority sum=%0d act=%b required 0 01", out_sum, out_act);
        end
        checks++;
        drainResult();
    endtask

`ifdef TERNARY_POPCOUNT_APPROX_EN
    task automatic test_approx();
        doBeat(16'h0007, 16'h0001, 1'b1, 0, 0);
        if (out_sum !== ACC_W'(2)) begin
            errors++;
            $display("[TB] FAIL approx_a sum=%0d required 2", out_sum);
        end
        checks++;
        drainResult();
        doBeat(16'h0001, 16'h0000, 1'b1, 0, 0);
        if (out_sum !== ACC_W'(0)) begin
            errors++;
            $display("[TB] FAIL approx_b sum=%0d required 0", out_sum);
        end
        checks++;
        drainResult();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int plan, s, hi, lo;
            logic [IN_W-1:0] p, q;
            logic l, closed, trunc;
            plan   = int'($urandom_range(MAX_BEATS + 1, 1));
            s      = 0;
            closed = 1'b0;
            trunc  = 1'b0;
            hi     = 0;
            lo     = 0;
            for (int k = 0; k < MAX_BEATS && !closed; k++) begin
                p  = IN_W'($urandom);
                q  = IN_W'($urandom);
                l  = (k == plan - 1);
                hi = int'($urandom_range(40)) - 20;
                lo = int'($urandom_range(40)) - 20;
                s  = s + pc(p) - pc(q);
                if (l || k == MAX_BEATS - 1) begin
                    closed = 1'b1;
                    trunc  = !l;
                end
                doBeat(p, q, l, hi, lo);
                if (!closed) repeat ($urandom_range(1)) begin @(posedge clk); #1; end
            end
            if (out_valid !== 1'b1 || out_sum !== ACC_W'(s) || out_act !== refAct(s, hi, lo) ||
                out_trunc !== trunc) begin
                errors++;
                $display("[TB] FAIL random n=%0d vld=%0b sum=%0d act=%b trunc=%0b required 1 %0d %b %0b",
                         n, out_valid, out_sum, out_act, out_trunc, s, refAct(s, hi, lo), trunc);
            end
            checks++;
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            drainResult();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pos    = '0;
        in_neg    = '0;
        in_last   = 1'b0;
        thr_hi    = '0;
        thr_lo    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset_pre_release();
        rst = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_truncation();
        test_thresholds();
`ifdef TERNARY_POPCOUNT_APPROX_EN
        test_approx();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic test_reset_pre_release();
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0) begin
            errors++;
            $display("[TB] FAIL reset_held rdy=%0b vld=%0b sum=%0d required 1 0 0",
                     in_ready, out_valid, out_sum);
        end
        checks++;
    endtask

endmodule
